// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the iCE40 PLL: pulses PLL reset, qualifies lock
// for a stable run length, then sequences the downstream system reset.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int HOLD_CYCLES    = 256,
    parameter int CNT_W          = 17
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic       locked,
    input  logic       soft_rst_req,
    input  logic       clear_flags,
    output logic       pll_resetb,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [3:0] retry_count,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   stab_q, stab_d;
    logic [3:0]         retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_resetb_q, pll_resetb_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic               meta_q, lock_s_q;
    logic               lost_set;

    // locked comes from the PLL's own analog lock detector, asynchronous here
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            meta_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            meta_q   <= locked;
            lock_s_q <= meta_q;
        end
    end

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            lock_lost_q  <= 1'b0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            lock_lost_q  <= lock_lost_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        stab_d   = '0;
        retry_d  = retry_q;
        lost_set = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                stab_d = lock_s_q ? stab_q + 1'b1 : '0;
                // acceptance wins over a coincident timeout
                if (lock_s_q && stab_q == STAB_LAST) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_PLL_RST;
                    if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!lock_s_q) begin
                    state_d  = ST_WAIT_LOCK;
                    lost_set = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d  = ST_WAIT_LOCK;
                    lost_set = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end
        lock_lost_d  = lost_set | (lock_lost_q & ~clear_flags);
        // outputs registered from next state so they switch with the state
        pll_resetb_d = (state_d != ST_PLL_RST);
        sys_rst_n_d  = (state_d == ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign state       = state_q;
    assign retry_count = retry_q;
    assign lock_lost   = lock_lost_q;

endmodule
